// File: rtl/viterbi_acs_scheduler.sv
// Viterbi add-compare-select scheduler for one trellis step.
// Each current tag gets a scan over every previous tag. The scan accumulates
// prev_score + trans_p with saturation and keeps the minimum and its back-pointer.
// The winner of each scan is emitted as a one-cycle result strobe.
module viterbi_acs_scheduler #(
    parameter int POS_num     = 11,
    parameter int POS_num_bit = 4,
    parameter int p_size      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   hold,
    output logic [POS_num_bit-1:0] previous_POS,
    output logic [POS_num_bit-1:0] current_POS,
    input  logic [p_size-1:0]      trans_p,
    input  logic [p_size-1:0]      prev_score,
    output logic                   res_valid,
    output logic [POS_num_bit-1:0] res_cur,
    output logic [p_size-1:0]      res_score,
    output logic [POS_num_bit-1:0] res_bp,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [POS_num_bit-1:0] LAST_IDX = POS_num_bit'(POS_num - 1);
    localparam logic [POS_num_bit-1:0] ONE_IDX  = POS_num_bit'(1);

    state_t                 state_q;
    logic [POS_num_bit-1:0] prev_q;
    logic [POS_num_bit-1:0] cur_q;
    logic [p_size-1:0]      best_score_q;
    logic [POS_num_bit-1:0] best_bp_q;
    logic                   res_valid_q;
    logic [POS_num_bit-1:0] res_cur_q;
    logic [p_size-1:0]      res_score_q;
    logic [POS_num_bit-1:0] res_bp_q;
    logic                   busy_q;
    logic                   done_q;

    logic [p_size:0]        sum_wide;
    logic [p_size-1:0]      sum_sat;
    logic [p_size-1:0]      best_score_d;
    logic [POS_num_bit-1:0] best_bp_d;

    // Add-compare-select: saturating sum and the candidate best for this prev index.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        best_score_d = best_score_q;
        best_bp_d    = best_bp_q;
        sum_wide     = {1'b0, prev_score} + {1'b0, trans_p};
        sum_sat      = sum_wide[p_size] ? {p_size{1'b1}} : sum_wide[p_size-1:0];
        if (prev_q == '0) begin
            // The first candidate of a scan always seeds the running minimum.
            best_score_d = sum_sat;
            best_bp_d    = '0;
        end else if (sum_sat < best_score_q) begin
            // A strict compare lets ties keep the lower previous index.
            best_score_d = sum_sat;
            best_bp_d    = prev_q;
        end
    end

    // Step sequencer with counters, best registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            cur_q        <= '0;
            best_score_q <= '0;
            best_bp_q    <= '0;
            res_valid_q  <= 1'b0;
            res_cur_q    <= '0;
            res_score_q  <= '0;
            res_bp_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every branch sees pre-edge register values.
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        prev_q  <= '0;
                        cur_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // While hold is high, the lookup data is not available, so everything freezes.
                    if (!hold) begin
                        best_score_q <= best_score_d;
                        best_bp_q    <= best_bp_d;
                        if (prev_q == LAST_IDX) begin
                            // The last candidate is folded in, so its winner goes straight to the outputs.
                            res_valid_q <= 1'b1;
                            res_cur_q   <= cur_q;
                            res_score_q <= best_score_d;
                            res_bp_q    <= best_bp_d;
                            state_q     <= S_EMIT;
                        end else begin
                            prev_q <= prev_q + ONE_IDX;
                        end
                    end
                end
                S_EMIT: begin
                    // hold is ignored here; the result strobe never stretches.
                    if (cur_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cur_q   <= cur_q + ONE_IDX;
                        prev_q  <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Addresses follow the counters; outside SCAN the counters are idle, so the addresses hold.
    assign previous_POS = prev_q;
    assign current_POS  = cur_q;
    assign res_valid    = res_valid_q;
    assign res_cur      = res_cur_q;
    assign res_score    = res_score_q;
    assign res_bp       = res_bp_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: doc/viterbi_acs_scheduler.md
VITERBI_ACS_SCHEDULER -- requirements
Module: viterbi_acs_scheduler

Interface
REQ-001 Parameter: POS_num, 11, number of POS tags (states).
REQ-002 Parameter: POS_num_bit, 4, width of a POS index.
REQ-003 Parameter: p_size, 32, width of a cost value.
REQ-004 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: start  in  1  pulse; begins one trellis step when sampled in IDLE.
REQ-007 Port: hold  in  1  stall; shared lookup resource unavailable this cycle.
REQ-008 Port: previous_POS  out  POS_num_bit  previous-tag address to transition lookup and score memory.
REQ-009 Port: current_POS  out  POS_num_bit  current-tag address to transition lookup.
REQ-010 Port: trans_p  in  p_size  unsigned cost for (previous_POS, current_POS), valid combinationally in the same cycle.
REQ-011 Port: prev_score  in  p_size  unsigned accumulated cost of previous_POS, valid combinationally in the same cycle.
REQ-012 Port: res_valid  out  1  one-cycle strobe; result for res_cur is valid.
REQ-013 Port: res_cur  out  POS_num_bit  current tag the result belongs to.
REQ-014 Port: res_score  out  p_size  minimum cost into res_cur.
REQ-015 Port: res_bp  out  POS_num_bit  back-pointer: previous tag that achieved res_score.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: done  out  1  one-cycle strobe after the last result of a step.

Function
REQ-018 The FSM SHALL have states IDLE, SCAN, EMIT, DONE, with all outputs decoded from registered state and counters.
REQ-019 IDLE: start=1 SHALL go to SCAN with prev counter=0 and cur counter=0; start outside IDLE SHALL be ignored.
REQ-020 SCAN: previous_POS SHALL equal the prev counter and current_POS the cur counter; in other states both SHALL hold their last values.
REQ-021 SCAN, hold=0: sum = prev_score + trans_p, computed at p_size+1 bits and saturated to all-ones on carry.
REQ-022 SCAN, hold=0, prev=0: best_score SHALL load sum and best_bp SHALL load 0 unconditionally.
REQ-023 SCAN, hold=0, prev>0: best registers SHALL update only when sum < best_score (strict); ties keep the lower prev index.
REQ-024 SCAN, hold=0: prev SHALL increment; when prev=POS_num-1 the FSM SHALL go to EMIT instead.
REQ-025 SCAN, hold=1: counters, best registers, and state SHALL freeze; address outputs SHALL stay stable.
REQ-026 EMIT: res_valid=1 for exactly one cycle, with res_cur=cur and res_score/res_bp taken from the best registers; hold SHALL NOT stall EMIT.
REQ-027 EMIT, cur<POS_num-1: cur SHALL increment, prev SHALL clear, and the FSM SHALL go to SCAN.
REQ-028 EMIT, cur=POS_num-1: the FSM SHALL go to DONE.
REQ-029 DONE: done=1 for one cycle, then the FSM SHALL go to IDLE; start in DONE SHALL be ignored.
REQ-030 With hold=0 throughout, a step SHALL take POS_num*(POS_num+1)+1 cycles from start acceptance to done (133 for POS_num=11).
REQ-031 res_score, res_bp, and res_cur SHALL retain their values after EMIT until the next EMIT.

Reset
REQ-032 rst=1 SHALL immediately force IDLE, clear the counters, and clear previous_POS, current_POS, res_cur, res_score, res_bp, best registers, res_valid, busy, and done to 0.
REQ-033 Reset mid-step SHALL abandon the step with no further res_valid or done; a new start SHALL be required.

Verification
REQ-034 Scenario: trans_p=10, prev_score=previous_POS*5, hold=0, start pulse -> 11 res_valid strobes, res_cur 0..10, each with res_score=10 and res_bp=0, then done at cycle 133.
REQ-035 Scenario: all costs equal (prev_score=7, trans_p=3) -> every res_score=10 and res_bp=0 (tie rule).
REQ-036 Scenario: prev_score=0xFFFFFFF0 and trans_p=0x20 everywhere except (prev 4, cur 2) with trans_p=1 -> res_score=0xFFFFFFFF for every cur except cur 2; cur 2 gives res_score=0xFFFFFFF1 and res_bp=4.
REQ-037 Scenario: hold=1 for 3 cycles during SCAN at prev=6 -> addresses stable, results identical to the no-hold run, done 3 cycles later.
REQ-038 Scenario: rst asserted during SCAN of cur=5, then start pulsed again -> outputs clear immediately, no done from the aborted step, and the new step completes normally.
REQ-039 Scenario: start held high through a whole step -> a second step begins only after DONE returns to IDLE.
